if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//   Receive side of the instruction-fetch interface. Accepts {instruction, PC_Out, PC_plus4}
//   from the fetch stage under a valid/ready handshake and buffers it in a small FIFO.
//   Presents the oldest entry to the decode stage under a second valid/ready handshake.
//   Decouples fetch from decode stalls and discards all in-flight fetches on a taken branch.
// PARAMETERS
//   DEPTH   2    number of entries; power of two, >= 2
//   AW      1    pointer width = log2(DEPTH)
//   NOP     32'h00000013  instruction word driven on id_instruction when empty (addi x0,x0,0)
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   asynchronous active-high reset
//   flush           in   1   branch_taken from execute; discard all entries
//   if_valid        in   1   fetch presents a word this cycle
//   if_ready        out  1   queue can accept a word this cycle
//   if_instruction  in   32  fetched instruction
//   if_pc           in   32  PC of fetched instruction
//   if_pc_plus4     in   32  PC+4 of fetched instruction
//   id_valid        out  1   head entry valid for decode
//   id_ready        in   1   decode consumes head this cycle
//   id_instruction  out  32  head instruction, NOP when empty
//   id_pc           out  32  head PC, 0 when empty
//   id_pc_plus4     out  32  head PC+4, 0 when empty
//   count           out  AW+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Storage: DEPTH x 96-bit entries, wr_ptr/rd_ptr AW bits, wrap modulo DEPTH; count AW+1 bits.
//   - push = if_valid & if_ready & ~flush; pop = id_valid & id_ready & ~flush.
//   - if_ready = (count != DEPTH); depends only on registered state (no path from id_ready).
//   - id_valid = (count != 0); head outputs are a mux of registered entries (no bypass).
//   - Latency: word pushed at edge N is visible on id_* after edge N (one cycle min).
//   - State by count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
//     EMPTY: push only -> PARTIAL (or FULL if DEPTH==1, disallowed). pop ignored.
//     PARTIAL: push&pop -> same count, both pointers advance; push -> count+1; pop -> count-1.
//     FULL: push impossible (if_ready=0); pop -> count-1, if_ready high next cycle.
//   - Empty + push + id_ready same cycle: word stored, not consumed; pop occurs later.
//   - flush (synchronous): next edge wr_ptr=rd_ptr=count=0; concurrent push and pop are both
//     dropped; entry contents need not be cleared. flush has priority over all events.
//   - Entries are held unchanged while id_ready is low (stall); no overwrite when FULL.
//   - Reset (async, any cycle, mid-transfer included): pointers/count = 0, id_valid = 0,
//     if_ready = 1, id_instruction = NOP, id_pc = 0, id_pc_plus4 = 0, count = 0.
//   - In-order delivery: words leave in exactly push order; none duplicated or lost except by
//     flush/reset.
// TESTING
//   1 rst pulse mid-stream with 2 entries -> id_valid=0, count=0, if_ready=1, id_instruction=32'h13
//     asynchronously.
//   2 push PC 0x0,0x4,0x8 with id_ready=0 -> count=2, if_ready=0 after 2nd, 0x8 held off;
//     id_pc stays 0x0.
//   3 FULL, id_ready=1 3 cycles, if_valid=1 -> id_pc sequence 0x0,0x4,0x8, no loss,
//     count never > 2.
//   4 count=1, push&pop same edge repeatedly 8 cycles -> count stays 1, pointers wrap,
//     order preserved.
//   5 flush with count=2 and if_valid=1, id_ready=1 -> next cycle count=0, id_valid=0,
//     pushed word absent.
//   6 empty, push PC 0x40 with id_ready=1 -> id_valid=0 that cycle, id_pc=0x40 and id_valid=1 next.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: a small FIFO with valid/ready handshakes on both sides.
// A synchronous flush discards every in-flight entry, and an empty queue presents a NOP.
module if_id_queue #(
    parameter int          DEPTH = 2,
    parameter int          AW    = 1,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [31:0]   if_instruction,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_pc_plus4,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instruction,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pc_plus4,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [95:0]   head;
    logic          push;
    logic          pop;

    // if_ready and id_valid come only from the registered count, so neither
    // handshake has a combinational path to the other side.
    assign if_ready = (count != FULL_CNT);
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {if_instruction, if_pc, if_pc_plus4};
    end

    always_comb begin
        head           = mem[rd_ptr];
        id_instruction = NOP;
        id_pc          = '0;
        id_pc_plus4    = '0;
        if (id_valid) begin
            id_instruction = head[95:64];
            id_pc          = head[63:32];
            id_pc_plus4    = head[31:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a per-cycle vector table plus hand-written
// reset sequences, compared against hand-computed values.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;

    if_id_queue #(.DEPTH(2), .AW(1), .NOP(32'h00000013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instruction(id_instruction), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  ecnt;
        logic        eifr;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h1337};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic rdy);
        flush          = fl;
        if_valid       = iv;
        if_pc          = pc;
        if_instruction = instr_of(pc);
        if_pc_plus4    = pc + 32'd4;
        id_ready       = rdy;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [1:0] ecnt, input logic eifr);
        chk({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, ev});
        chk({tag, " count"}, {30'd0, count}, {30'd0, ecnt});
        chk({tag, " if_ready"}, {31'd0, if_ready}, {31'd0, eifr});
        chk({tag, " id_pc"}, id_pc, ev ? epc : 32'd0);
        chk({tag, " id_instruction"}, id_instruction, ev ? instr_of(epc) : 32'h00000013);
        chk({tag, " id_pc_plus4"}, id_pc_plus4, ev ? epc + 32'd4 : 32'd0);
    endtask

    initial begin
        //          flush iv  pc          rdy  ev  epc         cnt  ifr
        // stall fill: third word held off while full
        vecs[0]  = '{1'b0, 1'b1, 32'h000, 1'b0, 1'b1, 32'h000, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 32'h004, 1'b0, 1'b1, 32'h000, 2'd2, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h008, 1'b0, 1'b1, 32'h000, 2'd2, 1'b0};
        // drain from full with fetch still offering 0x8
        vecs[3]  = '{1'b0, 1'b1, 32'h008, 1'b1, 1'b1, 32'h004, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h008, 1'b1, 1'b1, 32'h008, 2'd1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 2'd0, 1'b1};
        // empty + push + id_ready: stored, not consumed
        vecs[6]  = '{1'b0, 1'b1, 32'h040, 1'b1, 1'b1, 32'h040, 2'd1, 1'b1};
        // steady push&pop at count 1, pointers wrap
        for (int k = 0; k < 8; k++)
            vecs[7+k] = '{1'b0, 1'b1, 32'h044 + 32'(4*k), 1'b1, 1'b1, 32'h044 + 32'(4*k), 2'd1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h060, 2'd2, 1'b0};
        // flush when full, then refill shows old words gone
        vecs[16] = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h000, 2'd0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 2'd1, 1'b1};
        // flush beats a concurrent push and pop
        vecs[18] = '{1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h000, 2'd0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h500, 2'd1, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 32'h504, 1'b0, 1'b1, 32'h500, 2'd2, 1'b0};
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_state("reset", 1'b0, 32'h0, 2'd0, 1'b1);
        rst = 1'b0;

        // the vector (vs) expectation for cycle 5 also covers test 6's pre-edge id_valid=0
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].rdy);
            @(negedge clk);
            check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt, vecs[i].eifr);
        end

        // asynchronous reset mid-cycle with two entries and an active push
        drive(1'b0, 1'b1, 32'h600, 1'b1);
        #2 rst = 1'b1;
        #1 check_state("async_rst", 1'b0, 32'h0, 2'd0, 1'b1);
        @(negedge clk);
        check_state("rst_held", 1'b0, 32'h0, 2'd0, 1'b1);
        rst = 1'b0;

        // first push after reset appears after one edge
        drive(1'b0, 1'b1, 32'h700, 1'b1);
        chk("post_rst pre-edge id_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        check_state("post_rst", 1'b1, 32'h700, 2'd1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_state("post_rst drain", 1'b0, 32'h0, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
